cf_fft_1024_8_reorder: RTL and testbench
========================================

// Module: cf_fft_1024_8_reorder
// PURPOSE
//  Output reorder stage placed directly downstream of the 1024-point, 8-stage streaming FFT core.
//  - Consumes the core's sync/real/imag stream, which arrives in bit-reversed frequency order.
//  - Re-emits each frame in natural order (X[0]..X[N-1]).
//  - Ping-pong buffer: one bank is written while the other is read, so full streaming rate is sustained.
// PARAMETERS
//  LOG2N  10  log2 of frame length N (N = 1024)
//  WIDTH  16  bits per real/imag component
// PORTS
//  clock_c   in   1      single clock, rising edge
//  reset     in   1      asynchronous, active-high reset
//  enable    in   1      clock enable; all state advances only when 1
//  in_sync   in   1      first sample of an input frame (driven by FFT core o1)
//  in_re     in   WIDTH  real part, bit-reversed order (core o2)
//  in_im     in   WIDTH  imag part, bit-reversed order (core o3)
//  out_sync  out  1      marks X[0] of an output frame
//  out_valid out  1      out_re/out_im carry a valid sample
//  out_re    out  WIDTH  real part, natural order
//  out_im    out  WIDTH  imag part, natural order
// BEHAVIOUR
//  - Reset: out_sync=0, out_valid=0, out_re=0, out_im=0; wcnt=0, rcnt=0; write state IDLE; read idle; wbank=0.
//    RAM contents are not reset.
//  - enable=0: no counter, state, RAM or output register changes; outputs hold.
//  - All cycles below are enabled cycles.
//  - Write states:
//    - IDLE: in_sync=1 -> write sample to bank[wbank] at address 0, set wcnt=1, go WRITE.
//    - WRITE: each cycle write in_re/in_im to bank[wbank] at address bitrev(wcnt), then wcnt++.
//    - When wcnt=N-1 is written: toggle wbank, start a read of the just-filled bank, wcnt=0.
//      Next state is IDLE, or WRITE if in_sync=1 in the following cycle (back-to-back, no gap).
//    - in_sync=1 while in WRITE with wcnt!=0 (premature sync):
//      - abort the partial frame; wbank is not toggled;
//      - the sample is written at address 0 and wcnt=1;
//      - any read in progress continues unaffected.
//  - Read:
//    - Starts when a bank completes; reads address rcnt = 0..N-1 in natural order, one per cycle.
//    - Uses a synchronous RAM read; output registers are loaded one cycle after each address.
//    - out_valid=1 for exactly N consecutive enabled cycles; out_sync=1 only with rcnt=0 data.
//  - Latency: in_sync -> out_sync = N+1 enabled cycles (1025).
//    The last input sample (wcnt=N-1) precedes X[0] on the output by 2 cycles.
//  - Sustained streaming: read of frame k ends exactly as write of frame k+1 completes.
//    There is no overlap or collision; a new read never starts while a read is active.
//  - Gaps between frames allowed:
//    - after the read drains, out_valid=0 and out_re/out_im hold their last value;
//    - a sync arriving while in IDLE is always accepted.
//  - Reset asserted mid-operation clears all state immediately (async).
//    The partial frame and the pending read are discarded; the first post-reset in_sync starts clean.
//  - Data is stored and passed bit-exact; no scaling, rounding or sign change.
//  - Bank memory: 2 x N x 2*WIDTH, inferred RAM, one write port and one read port.
// CONFIGURATION
//  - `CF_FFT_REORDER_ERR_EN defined:
//    - adds output port frame_err (1 bit, reset 0);
//    - frame_err sets on any premature-sync abort and stays set until reset.
//  - Not defined: the port is absent; the abort behaviour is unchanged but silent.
// TESTING
//  T1 Reset: assert reset with random inputs toggling -> out_sync=0, out_valid=0, out_re=out_im=0.
//  T2 Single frame: sync + sample k carries in_re=bitrev(k), in_im=-bitrev(k), enable=1
//     -> out_sync at cycle 1025 after in_sync; out_re=0,1,...,1023, out_im=0,-1,...,-1023; out_valid for 1024 cycles.
//  T3 Back-to-back 3 frames (frame f: in_re=f*1024+bitrev(k))
//     -> 3072 contiguous valid outputs; natural order within each frame; out_sync every 1024 cycles.
//  T4 Enable stalls: random 30% enable=0 during T2 -> identical output sequence; outputs hold during stalls.
//  T5 Premature sync at wcnt=500, then full frame -> partial frame never output; full frame emerges 1025 cycles
//     after the second sync; frame_err=1 if `CF_FFT_REORDER_ERR_EN.
//  T6 Async reset pulse at read rcnt=300 -> outputs cleared in the same cycle; the next frame reorders correctly.

Source files
------------

// File: rtl/cf_fft_1024_8_reorder.sv
// cf_fft_1024_8_reorder
//   Output reorder stage for the 1024-point streaming FFT core. Frames arrive
//   in bit-reversed frequency order and are re-emitted in natural order
//   (X[0]..X[N-1]) through a ping-pong buffer. One bank fills while the other
//   drains, so back-to-back frames stream at full rate.
//
// Ports
//   clock_c    rising-edge clock
//   reset      asynchronous, active-high reset
//   enable     clock enable; all state advances only when 1
//   in_sync    first sample of an input frame
//   in_re/im   input sample, bit-reversed order
//   out_sync   marks X[0] of an output frame
//   out_valid  out_re/out_im carry a valid sample
//   out_re/im  output sample, natural order
//   frame_err  (only with CF_FFT_REORDER_ERR_EN) sticky premature-sync flag
//
// Configuration macro: CF_FFT_REORDER_ERR_EN adds the frame_err port.
//
// Timing: the last input sample (wcnt=N-1) starts the read; the RAM read
// register is loaded on the next enabled edge and the output registers on the
// one after, giving in_sync -> out_sync = N+1 enabled cycles.

module cf_fft_1024_8_reorder #(
  parameter int LOG2N = 10,
  parameter int WIDTH = 16
) (
  input  logic             clock_c,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_sync,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
`ifdef CF_FFT_REORDER_ERR_EN
  ,
  output logic             frame_err
`endif
);

  typedef enum logic {S_IDLE, S_WRITE} wstate_t;

  wstate_t              wstate;
  logic [LOG2N-1:0]     wcnt;
  logic [LOG2N-1:0]     rcnt;
  logic                 wbank;
  logic                 rbank;
  logic                 rd_active;
  // vld_pipe[0]: RAM read register holds data; vld_pipe[1] mirrors out_valid
  logic [1:0]           vld_pipe;
  logic                 sync_s1;
  logic [2*WIDTH-1:0]   rdata;
  logic [2*WIDTH-1:0]   mem [0:(2<<LOG2N)-1];

  logic                 premature;
  logic                 last_wr;
  logic                 wr_en;
  logic [LOG2N-1:0]     waddr;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // A sync seen mid-frame restarts the frame in the same bank.
  assign premature = (wstate == S_WRITE) && in_sync && (wcnt != '0);
  assign last_wr   = (wstate == S_WRITE) && !in_sync && (wcnt == '1);
  assign wr_en     = enable && (in_sync || (wstate == S_WRITE));
  assign waddr     = in_sync ? '0 : bitrev(wcnt);

  // Write side: frame fill state machine
  always_ff @(posedge clock_c or posedge reset) begin
    if (reset) begin
      wstate <= S_IDLE;
      wcnt   <= '0;
      wbank  <= 1'b0;
`ifdef CF_FFT_REORDER_ERR_EN
      frame_err <= 1'b0;
`endif
    end else if (enable) begin
      case (wstate)
        S_IDLE: begin
          if (in_sync) begin
            wcnt   <= LOG2N'(1);
            wstate <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (premature) begin
            wcnt <= LOG2N'(1);
`ifdef CF_FFT_REORDER_ERR_EN
            frame_err <= 1'b1;
`endif
          end else if (last_wr) begin
            wbank  <= ~wbank;
            wcnt   <= '0;
            wstate <= S_IDLE;
          end else begin
            wcnt <= wcnt + LOG2N'(1);
          end
        end
        default: wstate <= S_IDLE;
      endcase
    end
  end

  // Read side: natural-order address sweep plus the two-stage output pipe.
  // A new read only ever starts on the edge the previous one issues its last
  // address, so the restart simply overrides the stop.
  always_ff @(posedge clock_c or posedge reset) begin
    if (reset) begin
      rd_active <= 1'b0;
      rcnt      <= '0;
      rbank     <= 1'b0;
      vld_pipe  <= '0;
      sync_s1   <= 1'b0;
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (enable) begin
      if (last_wr) begin
        rd_active <= 1'b1;
        rcnt      <= '0;
        rbank     <= wbank;
      end else if (rd_active) begin
        rcnt <= rcnt + LOG2N'(1);
        if (rcnt == '1) rd_active <= 1'b0;
      end
      vld_pipe  <= {vld_pipe[0], rd_active};
      sync_s1   <= rd_active && (rcnt == '0);
      out_valid <= vld_pipe[0];
      out_sync  <= sync_s1;
      if (vld_pipe[0]) begin
        out_re <= rdata[2*WIDTH-1:WIDTH];
        out_im <= rdata[WIDTH-1:0];
      end
    end
  end

  // Bank memory: one write port, one registered read port, no reset
  always_ff @(posedge clock_c) begin
    if (enable) begin
      if (wr_en) mem[{wbank, waddr}] <= {in_re, in_im};
      if (rd_active) rdata <= mem[{rbank, rcnt}];
    end
  end

endmodule

// File: tb/tb_cf_fft_1024_8_reorder.sv
// Directed bench for cf_fft_1024_8_reorder: reset, single frame, back-to-back
// frames, enable stalls, premature sync and an asynchronous reset mid-read.
// Expected outputs are computed from the input patterns (a frame written with
// in_re = f(bitrev(k)) must read back as f(k) in natural order).

module tb_cf_fft_1024_8_reorder;
  localparam int N = 1024;

  logic        clock_c = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_sync;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic        out_sync;
  logic        out_valid;
  logic [15:0] out_re;
  logic [15:0] out_im;
`ifdef CF_FFT_REORDER_ERR_EN
  logic        frame_err;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] last_re = 16'h0;
  logic [15:0] last_im = 16'h0;

  cf_fft_1024_8_reorder #(.LOG2N(10), .WIDTH(16)) dut (
    .clock_c(clock_c), .reset(reset), .enable(enable), .in_sync(in_sync),
    .in_re(in_re), .in_im(in_im), .out_sync(out_sync), .out_valid(out_valid),
    .out_re(out_re), .out_im(out_im)
`ifdef CF_FFT_REORDER_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clock_c = ~clock_c;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] br(input int a);
    logic [9:0] v;
    logic [9:0] r;
    v = a[9:0];
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return {6'b0, r};
  endfunction

  // Drive inputs at the falling edge, return 1 time unit after the rising edge
  task automatic tick(input logic en, input logic s, input logic [15:0] r, input logic [15:0] i);
    @(negedge clock_c);
    enable = en; in_sync = s; in_re = r; in_im = i;
    @(posedge clock_c);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      tests++;
      if ({out_valid, out_sync, out_re, out_im} !== 34'h0) begin
        fails++;
        $display("FAIL reset c=%0d got v=%b s=%b re=%h im=%h need all zero", c, out_valid, out_sync, out_re, out_im);
      end
    end
`ifdef CF_FFT_REORDER_ERR_EN
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_frame_err got %b need 0", frame_err);
    end
`endif
    @(negedge clock_c);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 1'b0, 16'h0, 16'h0);
      tests++;
      if ({out_valid, out_sync, out_re, out_im} !== 34'h0) begin
        fails++;
        $display("FAIL post_reset_idle c=%0d got v=%b s=%b re=%h im=%h need all zero", c, out_valid, out_sync, out_re, out_im);
      end
    end
    last_re = 16'h0; last_im = 16'h0;
  endtask

  task automatic test_single_frame();
    logic        ev, es;
    logic [15:0] r, er, ei;
    for (int c = 0; c < 2*N + 8; c++) begin
      r = (c < N) ? br(c) : 16'h0;
      tick(1'b1, c == 0, r, 16'h0 - r);
      if (c >= N + 1 && c < 2*N + 1) begin
        ev = 1'b1; es = (c == N + 1);
        last_re = 16'(c - N - 1); last_im = 16'h0 - last_re;
      end else begin
        ev = 1'b0; es = 1'b0;
      end
      er = last_re; ei = last_im;
      tests++;
      if ({out_valid, out_sync, out_re, out_im} !== {ev, es, er, ei}) begin
        fails++;
        $display("FAIL single c=%0d got v=%b s=%b re=%0d im=%0d need v=%b s=%b re=%0d im=%0d",
                 c, out_valid, out_sync, out_re, out_im, ev, es, er, ei);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        ev, es;
    logic [15:0] r, er, ei;
    int          f, k, j;
    for (int c = 0; c < 4*N + 8; c++) begin
      f = c / N; k = c % N;
      r = (c < 3*N) ? 16'(f*N) + br(k) : 16'h0;
      tick(1'b1, (c < 3*N) && (k == 0), r, (c < 3*N) ? 16'h0 - br(k) : 16'h0);
      j = c - N - 1;
      if (j >= 0 && j < 3*N) begin
        ev = 1'b1; es = (j % N == 0);
        last_re = 16'(j); last_im = 16'h0 - 16'(j % N);
      end else begin
        ev = 1'b0; es = 1'b0;
      end
      er = last_re; ei = last_im;
      tests++;
      if ({out_valid, out_sync, out_re, out_im} !== {ev, es, er, ei}) begin
        fails++;
        $display("FAIL back_to_back c=%0d got v=%b s=%b re=%0d im=%0d need v=%b s=%b re=%0d im=%0d",
                 c, out_valid, out_sync, out_re, out_im, ev, es, er, ei);
      end
    end
  endtask

  // Disabled cycles carry junk inputs; outputs must hold their last value
  task automatic test_stall();
    logic        en, ev, es;
    logic [15:0] r, er, ei;
    int          e;
    e = 0; ev = 1'b0; es = 1'b0; er = last_re; ei = last_im;
    for (int c = 0; c < 8000 && e < 2*N + 8; c++) begin
      en = ($urandom_range(0, 9) >= 3);
      if (!en) tick(1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
      else begin
        r = (e < N) ? br(e) : 16'h0;
        tick(1'b1, e == 0, r, 16'h0 - r);
        if (e >= N + 1 && e < 2*N + 1) begin
          ev = 1'b1; es = (e == N + 1);
          er = 16'(e - N - 1); ei = 16'h0 - er;
        end else begin
          ev = 1'b0; es = 1'b0;
        end
        e++;
      end
      tests++;
      if ({out_valid, out_sync, out_re, out_im} !== {ev, es, er, ei}) begin
        fails++;
        $display("FAIL stall c=%0d en=%b got v=%b s=%b re=%0d im=%0d need v=%b s=%b re=%0d im=%0d",
                 c, en, out_valid, out_sync, out_re, out_im, ev, es, er, ei);
      end
    end
    tests++;
    if (e < 2*N + 8) begin
      fails++;
      $display("FAIL stall_budget enabled_cycles=%0d need %0d", e, 2*N + 8);
    end
    last_re = er; last_im = ei;
  endtask

  // Partial frame (marked 0x7xxx) aborted at wcnt=500 must never appear
  task automatic test_premature();
    logic        ev, es;
    logic [15:0] r, ri, er, ei;
    int          k;
    for (int c = 0; c < 500 + 2*N + 8; c++) begin
      k = c - 500;
      if (c < 500) begin
        r = 16'h7000 | 16'(c); ri = 16'h7000;
      end else if (k < N) begin
        r = 16'h2000 + br(k); ri = 16'h0 - br(k);
      end else begin
        r = 16'h0; ri = 16'h0;
      end
      tick(1'b1, (c == 0) || (c == 500), r, ri);
      k = c - 501 - N;
      if (k >= 0 && k < N) begin
        ev = 1'b1; es = (k == 0);
        last_re = 16'h2000 + 16'(k); last_im = 16'h0 - 16'(k);
      end else begin
        ev = 1'b0; es = 1'b0;
      end
      er = last_re; ei = last_im;
      tests++;
      if ({out_valid, out_sync, out_re, out_im} !== {ev, es, er, ei}) begin
        fails++;
        $display("FAIL premature c=%0d got v=%b s=%b re=%h im=%h need v=%b s=%b re=%h im=%h",
                 c, out_valid, out_sync, out_re, out_im, ev, es, er, ei);
      end
    end
`ifdef CF_FFT_REORDER_ERR_EN
    tests++;
    if (frame_err !== 1'b1) begin
      fails++;
      $display("FAIL premature_frame_err got %b need 1", frame_err);
    end
`endif
  endtask

  // Reset while frame A is read at rcnt~300 and frame B is half written
  task automatic test_async_reset();
    logic        ev, es;
    logic [15:0] r, er, ei;
    for (int c = 0; c < N + 302; c++) begin
      r = br(c % N);
      tick(1'b1, (c % N) == 0, r, 16'h0 - r);
    end
    tests++;
    if ({out_valid, out_sync, out_re} !== {1'b1, 1'b0, 16'd300}) begin
      fails++;
      $display("FAIL pre_reset_read got v=%b s=%b re=%0d need v=1 s=0 re=300", out_valid, out_sync, out_re);
    end
    @(negedge clock_c);
    reset = 1'b1;
    #1;
    tests++;
    if ({out_valid, out_sync, out_re, out_im} !== 34'h0) begin
      fails++;
      $display("FAIL async_reset got v=%b s=%b re=%h im=%h need all zero", out_valid, out_sync, out_re, out_im);
    end
`ifdef CF_FFT_REORDER_ERR_EN
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_frame_err got %b need 0", frame_err);
    end
`endif
    tick(1'b1, 1'b1, 16'hffff, 16'hffff);
    @(negedge clock_c);
    reset = 1'b0;
    last_re = 16'h0; last_im = 16'h0;
    for (int c = 0; c < 2*N + 8; c++) begin
      r = (c < N) ? (br(c) ^ 16'h0055) : 16'h0;
      tick(1'b1, c == 0, r, (c < N) ? 16'h0 - br(c) : 16'h0);
      if (c >= N + 1 && c < 2*N + 1) begin
        ev = 1'b1; es = (c == N + 1);
        last_re = 16'(c - N - 1) ^ 16'h0055; last_im = 16'h0 - 16'(c - N - 1);
      end else begin
        ev = 1'b0; es = 1'b0;
      end
      er = last_re; ei = last_im;
      tests++;
      if ({out_valid, out_sync, out_re, out_im} !== {ev, es, er, ei}) begin
        fails++;
        $display("FAIL after_reset c=%0d got v=%b s=%b re=%h im=%h need v=%b s=%b re=%h im=%h",
                 c, out_valid, out_sync, out_re, out_im, ev, es, er, ei);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_sync = 1'b0; in_re = 16'h0; in_im = 16'h0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_premature();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
